// File: rtl/fetch_decode.sv
// fetch_decode: fetches 8-bit instructions, resolves jumps locally and presents decoded fields downstream.
// Optional FETCH_DECODE_SELF_JUMP_HALT_EN: a jump to its own address enters HALT.
module fetch_decode (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       imem_req,
    output logic [7:0] imem_addr,
    input  logic       imem_ack,
    input  logic [7:0] imem_rdata,
    output logic       id_valid,
    input  logic       id_ready,
    output logic [1:0] id_opcode,
    output logic [1:0] id_rs,
    output logic [1:0] id_rt,
    output logic [1:0] id_imm,
    output logic [7:0] id_pc,
    output logic [7:0] pc,
    output logic       halted,
    output logic [7:0] instr_count
);
    typedef enum logic [1:0] {IDLE, FETCH, DECODE, HALT} state_t;
    state_t state, state_nx;
    logic [7:0] pc_nx, cnt_nx, seq_pc, jmp_pc;
    logic is_jump, self_jump, load;
    assign is_jump = imem_rdata[7:6] == 2'b11;
    assign seq_pc = pc + 8'd1;
    assign jmp_pc = seq_pc + {{2{imem_rdata[5]}}, imem_rdata[5:0]};
    assign load = state == FETCH && imem_ack && !is_jump;
    assign imem_addr = pc;
`ifdef FETCH_DECODE_SELF_JUMP_HALT_EN
    assign self_jump = imem_rdata[5:0] == 6'h3f;
    assign halted = state == HALT;
`else
    assign self_jump = 1'b0;
    assign halted = 1'b0;
`endif
    always_comb begin
        state_nx = state;
        pc_nx = pc;
        cnt_nx = instr_count;
        imem_req = 1'b0;
        id_valid = 1'b0;
        case (state)
            IDLE: state_nx = start ? FETCH : IDLE;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    pc_nx = is_jump ? jmp_pc : seq_pc;
                    cnt_nx = is_jump ? instr_count + 8'd1 : instr_count;
                    state_nx = !is_jump ? DECODE : self_jump ? HALT : FETCH;
                end
            end
            DECODE: begin
                id_valid = 1'b1;
                cnt_nx = id_ready ? instr_count + 8'd1 : instr_count;
                state_nx = id_ready ? FETCH : DECODE;
            end
            default: state_nx = HALT;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc <= 8'h00;
            instr_count <= 8'h00;
            {id_opcode, id_rs, id_rt, id_imm} <= 8'h00;
            id_pc <= 8'h00;
        end else begin
            state <= state_nx;
            pc <= pc_nx;
            instr_count <= cnt_nx;
            if (load) begin
                {id_opcode, id_rs, id_rt, id_imm} <= imem_rdata;
                id_pc <= pc;
            end
        end
    end
endmodule

// File: tb/tb_fetch_decode.sv
// tb_fetch_decode: directed vector table, hand corner sequences and a randomized run against an ISA-level model.
module tb_fetch_decode;
    logic clk = 0, rst_n = 0, start = 0, imem_ack = 0, id_ready = 0;
    logic [7:0] imem_rdata = 0;
    logic imem_req, id_valid, halted;
    logic [7:0] imem_addr, id_pc, pc, instr_count;
    logic [1:0] id_opcode, id_rs, id_rt, id_imm;
    int errors = 0, checks = 0;

    fetch_decode dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_imm(id_imm),
        .id_pc(id_pc), .pc(pc), .halted(halted), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] sp, ins;
        logic       jmp;
        logic [1:0] op, rs, rt, imm;
        logic [7:0] nxt;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 0; start = 0; imem_ack = 0; id_ready = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic fetch_ack(input logic [7:0] d);
        int n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!imem_req) chk("req_timeout", 0, 1);
        imem_ack = 1; imem_rdata = d;
        @(negedge clk);
        imem_ack = 0;
    endtask

    task automatic go_to(input logic [7:0] t);
        do_reset();
        start = 1;
        @(negedge clk);
        start = 0;
        if (t != 8'h00) fetch_ack(8'hC0 | ((t - 8'd1) & 8'h3F));
    endtask

    vec_t v[6];
    logic [7:0] mem[256];
    logic [15:0] q[$];

    initial begin
        v[0] = '{8'h00, 8'h1B, 1'b0, 2'd0, 2'd1, 2'd2, 2'd3, 8'h01};
        v[1] = '{8'h05, 8'hC2, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 8'h08};
        v[2] = '{8'hFF, 8'h00, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 8'h00};
        v[3] = '{8'h02, 8'hF8, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 8'hFB};
        v[4] = '{8'h10, 8'h7E, 1'b0, 2'd1, 2'd3, 2'd3, 2'd2, 8'h11};
        v[5] = '{8'h00, 8'hE5, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 8'hE6};

        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_valid", id_valid, 0);
        chk("rst_pc", pc, 0);
        chk("rst_count", instr_count, 0);
        chk("rst_halted", halted, 0);
        chk("rst_fields", {id_opcode, id_rs, id_rt, id_imm, id_pc}, 0);

        do_reset();
        imem_ack = 1; imem_rdata = 8'h1B;
        repeat (3) @(negedge clk);
        chk("idle_ignores_ack", {imem_req, id_valid, pc}, 0);
        imem_ack = 0;

        foreach (v[i]) begin
            logic [7:0] base;
            go_to(v[i].sp);
            base = (v[i].sp != 8'h00) ? 8'd1 : 8'd0;
            fetch_ack(v[i].ins);
            if (v[i].jmp) begin
                chk($sformatf("v%0d_novalid", i), id_valid, 0);
                chk($sformatf("v%0d_req", i), imem_req, 1);
                chk($sformatf("v%0d_addr", i), imem_addr, v[i].nxt);
                chk($sformatf("v%0d_count", i), instr_count, base + 8'd1);
            end else begin
                chk($sformatf("v%0d_valid", i), id_valid, 1);
                chk($sformatf("v%0d_fields", i), {id_opcode, id_rs, id_rt, id_imm},
                    {v[i].op, v[i].rs, v[i].rt, v[i].imm});
                chk($sformatf("v%0d_idpc", i), id_pc, v[i].sp);
                chk($sformatf("v%0d_pc", i), pc, v[i].nxt);
                id_ready = 1;
                @(negedge clk);
                id_ready = 0;
                chk($sformatf("v%0d_refetch", i), {id_valid, imem_req}, 2'b01);
                chk($sformatf("v%0d_addr", i), imem_addr, v[i].nxt);
                chk($sformatf("v%0d_count", i), instr_count, base + 8'd1);
            end
        end

        go_to(8'h00);
        fetch_ack(8'h40);
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold", {id_valid, imem_req, id_opcode, id_rs, id_rt, id_imm, id_pc},
                {2'b10, 8'h40, 8'h00});
            @(negedge clk);
        end
        id_ready = 1;
        @(negedge clk);
        id_ready = 0;
        chk("bp_release", {id_valid, imem_req, imem_addr, instr_count}, {2'b01, 8'h01, 8'h01});

        go_to(8'h10);
        fetch_ack(8'hFF);
`ifdef FETCH_DECODE_SELF_JUMP_HALT_EN
        start = 1;
        for (int k = 0; k < 4; k++) begin
            chk("halt_state", {halted, imem_req, id_valid, pc}, {3'b100, 8'h10});
            @(negedge clk);
        end
        start = 0;
`else
        chk("selfjump_refetch", {halted, imem_req, imem_addr}, {2'b01, 8'h10});
        fetch_ack(8'hFF);
        chk("selfjump_again", {halted, imem_req, imem_addr, instr_count}, {2'b01, 8'h10, 8'h03});
`endif

        go_to(8'h05);
        imem_ack = 1; imem_rdata = 8'h1B;
        #2 rst_n = 0;
        #1;
        chk("async_rst", {imem_req, id_valid, pc, instr_count, halted}, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("rst_abort", {imem_req, id_valid, pc}, 0);
        @(negedge clk);
        imem_ack = 0;
        chk("rst_no_fetch", {imem_req, id_valid, instr_count}, 0);

        begin
            int mpc = 0;
            logic [7:0] mcount = 0;
            foreach (mem[a]) begin
                mem[a] = 8'($urandom);
                if (mem[a] == 8'hFF) mem[a] = 8'hFE;
            end
            do_reset();
            start = 1;
            @(negedge clk);
            start = 0;
            for (int c = 0; c < 4000; c++) begin
                chk("rnd_count", instr_count, mcount);
                imem_ack = 0; id_ready = 0;
                if (id_valid) begin
                    if (q.size() == 0) chk("rnd_dup", id_valid, 0);
                    else begin
                        chk("rnd_decode", {id_opcode, id_rs, id_rt, id_imm, id_pc}, q[0]);
                        if ($urandom_range(2) == 0) begin
                            id_ready = 1;
                            void'(q.pop_front());
                            mcount++;
                        end
                    end
                end
                if (imem_req) begin
                    if (q.size() != 0) chk("rnd_order", q.size(), 0);
                    if ($urandom_range(2) == 0) begin
                        logic [7:0] ins;
                        int off;
                        chk("rnd_addr", imem_addr, mpc);
                        imem_ack = 1;
                        imem_rdata = mem[imem_addr];
                        ins = mem[mpc];
                        if (ins[7:6] == 2'b11) begin
                            off = ins[5] ? int'(ins[5:0]) - 64 : int'(ins[5:0]);
                            mpc = (mpc + 1 + off + 256) % 256;
                            mcount++;
                        end else begin
                            q.push_back({ins, 8'(mpc)});
                            mpc = (mpc + 1) % 256;
                        end
                    end
                end
                @(negedge clk);
            end
            imem_ack = 0; id_ready = 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_decode.md
FETCH_DECODE -- requirements
Module: fetch_decode

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock (single clock domain).
REQ-002 SHALL have ports: rst_n  in  1  asynchronous reset, active-low.
REQ-003 SHALL have ports: start  in  1  one-cycle pulse, begins fetching from pc.
REQ-004 SHALL have ports: imem_req  out  1  instruction memory request; imem_addr  out  8  fetch address.
REQ-005 SHALL have ports: imem_ack  in  1  memory data valid; imem_rdata  in  8  fetched instruction.
REQ-006 SHALL have ports: id_valid  out  1  decoded instruction available; id_ready  in  1  downstream accepts.
REQ-007 SHALL have ports: id_opcode  out  2  = instr[7:6]; id_rs  out  2  = instr[5:4]; id_rt  out  2  = instr[3:2].
REQ-008 SHALL have ports: id_imm  out  2  = instr[1:0], the raw 2-bit immediate for the downstream sign extender (also the rd field); id_pc  out  8  address of the presented instruction.
REQ-009 SHALL have ports: pc  out  8  current program counter; halted  out  1  halt state indicator; instr_count  out  8  instructions retired.

Function
REQ-010 SHALL implement states IDLE, FETCH, DECODE, HALT; reset state IDLE.
REQ-011 IDLE: imem_req=0, id_valid=0; start=1 -> FETCH next cycle; imem_ack ignored.
REQ-012 FETCH: imem_req=1, imem_addr=pc, both held stable until imem_ack=1; start ignored.
REQ-013 On FETCH with imem_ack=1 and instr[7:6]!=2'b11: register instr fields and id_pc=pc, pc<=pc+1 (mod 256), -> DECODE.
REQ-014 On FETCH with imem_ack=1 and instr[7:6]==2'b11 (jump): pc<=pc+1+sext(instr[5:0]) mod 256, stay in FETCH, no id_valid, instr_count+=1.
REQ-015 DECODE: id_valid=1, all id_* outputs stable; id_valid&&id_ready -> FETCH next cycle, instr_count+=1 (wraps 255->0).
REQ-016 Minimum latency: imem_ack cycle N -> id_valid at N+1; accept at cycle M -> imem_req at M+1.
REQ-017 Memory wait unbounded; downstream backpressure unbounded; no instruction dropped or duplicated.
REQ-018 pc wraps 0xFF->0x00 on sequential fetch; jump target arithmetic modulo 256.
REQ-019 HALT: imem_req=0, id_valid=0, halted=1; exit only by reset.

Reset
REQ-020 rst_n=0 SHALL asynchronously force state IDLE, pc=0x00, id_*=0, id_valid=0, imem_req=0, halted=0, instr_count=0.
REQ-021 Reset asserted mid-FETCH or mid-DECODE SHALL abort the transaction; a pending imem_ack after release SHALL be ignored (IDLE).
REQ-022 Reset deassertion SHALL take effect at the next rising clk edge; no fetch until start.

Configuration
REQ-023 Macro FETCH_DECODE_SELF_JUMP_HALT_EN: when defined, a jump with instr[5:0]==6'b111111 (target == own address) SHALL enter HALT instead of FETCH, pc holds that address.
REQ-024 Without FETCH_DECODE_SELF_JUMP_HALT_EN: that jump SHALL behave as any jump (re-fetch same address forever), halted tied 0, HALT unreachable.

Verification
REQ-025 Reset, start, imem_rdata=0x1B ack 1 cycle, id_ready=1 -> id_valid 1 cycle, opcode=00, rs=01, rt=10, imm=11, id_pc=0x00, pc=0x01, count=1.
REQ-026 Fetch at pc=0x05, imem_rdata=0xC2 (jump +2) -> no id_valid, next imem_addr=0x08, count=1.
REQ-027 Instruction 0x40 acked, id_ready low 5 cycles -> id_valid and fields stable 5 cycles, no imem_req until accept.
REQ-028 pc=0xFF, non-jump 0x00 -> next imem_addr=0x00; pc=0x02, jump 0xF8 (-8) -> imem_addr=0xFB.
REQ-029 Macro defined, jump 0xFF at pc=0x10 -> halted=1, imem_req=0 permanently; macro undefined -> imem_addr=0x10 refetched.
REQ-030 rst_n low during FETCH with imem_ack=1 same cycle -> outputs cleared immediately, pc=0x00, no id_valid after release.
